// File: rtl/cmd_dispatch.sv
// Command dispatcher: strips leading command-ID tokens into a match path,
// forwards the remaining tokens as argument beats, then runs an executor handshake and reports a result.
module cmd_dispatch #(
  parameter int TOK_W     = 16,
  parameter int NUM_CMD   = 4,
  parameter int MAX_DEPTH = 2,
  parameter int MAX_ARGS  = 8,
  parameter int CODE_W    = 8,
  localparam int IDX_W    = $clog2(NUM_CMD + 1),
  localparam int DEP_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [TOK_W-1:0]           s_data,
  input  logic                       s_last,
  input  logic [NUM_CMD*TOK_W-1:0]   cmd_table,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [TOK_W-1:0]           m_data,
  output logic                       m_last,
  output logic                       x_go,
  output logic                       x_term,
  input  logic                       exec_done,
  input  logic [CODE_W-1:0]          exec_code,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [CODE_W-1:0]          r_code,
  output logic                       r_err,
  output logic [MAX_DEPTH*IDX_W-1:0] r_path,
  output logic [DEP_W-1:0]           r_depth
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a source holds valid and its payload stable until that edge.

  localparam int CNT_W = $clog2(MAX_ARGS + 1);
  localparam logic [DEP_W-1:0] MAX_DEP_L  = DEP_W'(MAX_DEPTH);
  localparam logic [CNT_W-1:0] MAX_ARGS_L = CNT_W'(MAX_ARGS);

  typedef enum logic [2:0] {
    ST_MATCH, ST_FWD, ST_DRAIN, ST_WAIT_EXEC, ST_RESULT
  } state_t;

  state_t                     state_q, state_d;
  logic                       m_valid_q, m_valid_d;
  logic [TOK_W-1:0]           m_data_q, m_data_d;
  logic                       m_last_q, m_last_d;
  logic                       x_go_q, x_go_d;
  logic                       x_term_q, x_term_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [DEP_W-1:0]           depth_q, depth_d;
  logic [MAX_DEPTH*IDX_W-1:0] path_q, path_d;
  logic                       term_q, term_d;
  logic                       err_q, err_d;
  logic [CODE_W-1:0]          code_q, code_d;
  logic                       in_done_q, in_done_d;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             tok_flag, tok_term, s_acc;

  assign tok_flag = s_data[TOK_W-1];
  assign tok_term = s_data[TOK_W-2];
  assign s_acc    = s_valid && s_ready;

  // Lowest matching slot wins; flag tokens never match a command.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_CMD; k++) begin
      if (!hit && !tok_flag && (s_data == cmd_table[k*TOK_W +: TOK_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    count_d   = count_q;
    depth_d   = depth_q;
    path_d    = path_q;
    term_d    = term_q;
    err_d     = err_q;
    code_d    = code_q;
    in_done_d = in_done_q;
    x_go_d    = 1'b0;
    x_term_d  = 1'b0;
    s_ready   = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      ST_MATCH: begin
        s_ready = !rst && (!m_valid_q || m_ready);
        if (s_acc) begin
          if (hit && (depth_q < MAX_DEP_L)) begin
            for (int l = 0; l < MAX_DEPTH; l++) begin
              if (DEP_W'(l) == depth_q) path_d[l*IDX_W +: IDX_W] = hit_idx;
            end
            depth_d = depth_q + 1'b1;
            if (s_last) begin
              x_go_d  = 1'b1;
              state_d = ST_WAIT_EXEC;
            end
          end else begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_last_d  = s_last;
            count_d   = CNT_W'(1);
            term_d    = tok_flag && tok_term;
            in_done_d = s_last;
            state_d   = ST_FWD;
          end
        end
      end

      ST_FWD: begin
        s_ready = !rst && !in_done_q && (!m_valid_q || m_ready);
        if (s_acc) begin
          if (count_q == MAX_ARGS_L) begin
            err_d   = 1'b1;
            state_d = s_last ? ST_RESULT : ST_DRAIN;
          end else begin
            m_valid_d = 1'b1;
            m_data_d  = s_data;
            m_last_d  = s_last;
            count_d   = count_q + 1'b1;
            term_d    = term_q || (tok_flag && tok_term);
            in_done_d = s_last;
          end
        end
        // in_done_q is set whenever m_last_q is, so this never collides with a load.
        if (m_valid_q && m_ready && m_last_q) begin
          x_go_d  = 1'b1;
          state_d = ST_WAIT_EXEC;
        end
      end

      ST_DRAIN: begin
        s_ready = !rst;
        if (s_acc && s_last) state_d = ST_RESULT;
      end

      ST_WAIT_EXEC: begin
        if (exec_done) begin
          code_d  = exec_code;
          state_d = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (r_ready) begin
          path_d    = '0;
          depth_d   = '0;
          count_d   = '0;
          term_d    = 1'b0;
          err_d     = 1'b0;
          code_d    = '0;
          in_done_d = 1'b0;
          state_d   = ST_MATCH;
        end
      end

      default: state_d = ST_MATCH;
    endcase

    x_term_d = x_go_d && term_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MATCH;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      x_go_q    <= 1'b0;
      x_term_q  <= 1'b0;
      count_q   <= '0;
      depth_q   <= '0;
      path_q    <= '0;
      term_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      in_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      x_go_q    <= x_go_d;
      x_term_q  <= x_term_d;
      count_q   <= count_d;
      depth_q   <= depth_d;
      path_q    <= path_d;
      term_q    <= term_d;
      err_q     <= err_d;
      code_q    <= code_d;
      in_done_q <= in_done_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign x_go    = x_go_q;
  assign x_term  = x_term_q;
  assign r_valid = (state_q == ST_RESULT);
  assign r_err   = r_valid && err_q;
  assign r_code  = !r_valid ? '0 : (err_q ? CODE_W'(1) : code_q);
  assign r_path  = path_q;
  assign r_depth = depth_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch: a job-level model predicts beats and results, a negedge
// compare process checks them, and per-test literals pin the model.
module tb_cmd_dispatch;

  localparam int TOK_W = 16, NUM_CMD = 4, MAX_DEPTH = 2, MAX_ARGS = 8, CODE_W = 8;
  localparam int IDX_W = 3, DEP_W = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       s_valid = 1'b0;
  logic                       s_ready;
  logic [TOK_W-1:0]           s_data = '0;
  logic                       s_last = 1'b0;
  logic [NUM_CMD*TOK_W-1:0]   cmd_table = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
  logic                       m_valid;
  logic                       m_ready = 1'b1;
  logic [TOK_W-1:0]           m_data;
  logic                       m_last;
  logic                       x_go, x_term;
  logic                       exec_done = 1'b0;
  logic [CODE_W-1:0]          exec_code = '0;
  logic                       r_valid;
  logic                       r_ready = 1'b0;
  logic [CODE_W-1:0]          r_code;
  logic                       r_err;
  logic [MAX_DEPTH*IDX_W-1:0] r_path;
  logic [DEP_W-1:0]           r_depth;

  cmd_dispatch #(.TOK_W(TOK_W), .NUM_CMD(NUM_CMD), .MAX_DEPTH(MAX_DEPTH),
                 .MAX_ARGS(MAX_ARGS), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .cmd_table(cmd_table), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .x_go(x_go), .x_term(x_term),
    .exec_done(exec_done), .exec_code(exec_code), .r_valid(r_valid), .r_ready(r_ready),
    .r_code(r_code), .r_err(r_err), .r_path(r_path), .r_depth(r_depth));

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  // scoreboard state
  logic [TOK_W:0]           exp_q[$];
  logic [TOK_W:0]           got_q[$];
  logic [TOK_W-1:0]         tok_a[0:15];
  int                       n_tok;
  logic [CODE_W-1:0]        job_code, exp_code;
  logic                     exp_err, exp_term, exp_go;
  logic [MAX_DEPTH*IDX_W-1:0] exp_path;
  logic [DEP_W-1:0]         exp_depth;
  int                       go_cnt = 0;
  logic                     go_due = 1'b0;
  logic                     stall_v = 1'b0;
  logic [TOK_W:0]           stall_b;
  logic                     last_term;
  logic [CODE_W-1:0]        last_code;
  logic                     last_err;
  logic [MAX_DEPTH*IDX_W-1:0] last_path;
  logic [DEP_W-1:0]         last_depth;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Job-level model: leading command IDs (up to MAX_DEPTH) form the path, the rest are args.
  task automatic prep(input int n, input logic [CODE_W-1:0] code);
    int depth, cnt, hit;
    bit matching;
    logic [TOK_W-1:0] t;
    n_tok = n; exp_err = 0; exp_term = 0; exp_path = '0;
    depth = 0; cnt = 0; matching = 1;
    for (int i = 0; i < n; i++) begin
      t = tok_a[i];
      hit = -1;
      if (!t[TOK_W-1])
        for (int k = 0; k < NUM_CMD; k++)
          if (hit < 0 && t == cmd_table[k*TOK_W +: TOK_W]) hit = k;
      if (matching && hit >= 0 && depth < MAX_DEPTH) begin
        exp_path[depth*IDX_W +: IDX_W] = IDX_W'(hit + 1);
        depth++;
      end else begin
        matching = 0;
        cnt++;
        if (cnt > MAX_ARGS) begin
          exp_err = 1;
          break;
        end
        if (t[TOK_W-1] && t[TOK_W-2]) exp_term = 1;
        exp_q.push_back({(i == n - 1), t});
      end
    end
    exp_depth = DEP_W'(depth);
    exp_go    = !exp_err;
    exp_code  = exp_err ? CODE_W'(1) : code;
    job_code  = code;
  endtask

  // driver tasks
  task automatic drive_tok(input logic [TOK_W-1:0] d, input logic last);
    int t;
    s_valid = 1'b1; s_data = d; s_last = last;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin
        timeout_fail("s_ready_wait");
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < n_tok; i++) drive_tok(tok_a[i], (i == n_tok - 1));
  endtask

  task automatic finish_job();
    int t;
    if (exp_go) begin
      t = 0;
      while (go_cnt == 0 && t < 100) begin
        @(negedge clk); #1;
        t++;
      end
      if (go_cnt == 0) timeout_fail("x_go_wait");
      @(posedge clk); #1;
      exec_done = 1'b1; exec_code = job_code;
      @(posedge clk); #1;
      exec_done = 1'b0; exec_code = '0;
    end
    t = 0;
    while (!r_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!r_valid) timeout_fail("r_valid_wait");
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic run_job(input int n, input logic [CODE_W-1:0] code);
    got_q.delete();
    prep(n, code);
    send_all();
    finish_job();
  endtask

  // compare process
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      go_cnt  = 0;
      go_due  = 1'b0;
      stall_v = 1'b0;
    end else begin
      if (go_due) chk("x_go_latency", 32'(x_go), 32'd1);
      go_due = m_valid && m_ready && m_last;
      if (stall_v && m_valid) chk("m_hold", 32'({m_last, m_data}), 32'(stall_b));
      stall_v = m_valid && !m_ready;
      stall_b = {m_last, m_data};
      if (m_valid && m_ready) begin
        got_q.push_back({m_last, m_data});
        if (exp_q.size() == 0) timeout_fail("m_beat_unexpected");
        else chk("m_beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
      end
      if (x_go) begin
        go_cnt++;
        last_term = x_term;
        chk("x_term", 32'(x_term), 32'(exp_term));
      end
      if (r_valid && r_ready) begin
        chk("r_code", 32'(r_code), 32'(exp_code));
        chk("r_err", 32'(r_err), 32'(exp_err));
        chk("r_path", 32'(r_path), 32'(exp_path));
        chk("r_depth", 32'(r_depth), 32'(exp_depth));
        chk("x_go_count", 32'(go_cnt), exp_go ? 32'd1 : 32'd0);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        last_code = r_code; last_err = r_err; last_path = r_path; last_depth = r_depth;
        go_cnt = 0;
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_x_go", 32'({x_go, x_term}), 32'd0);
    chk("rst_r_out", 32'({r_valid, r_err, r_code, r_path, r_depth}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // stray exec_done while idle must not leak into the next result
    exec_done = 1'b1; exec_code = 8'h55;
    @(posedge clk); #1;
    exec_done = 1'b0; exec_code = '0;

    // two-level match, one argument
    tok_a[0] = 16'h0010; tok_a[1] = 16'h0020; tok_a[2] = 16'h0005;
    run_job(3, 8'd3);
    chk("t1_nbeats", 32'(got_q.size()), 32'd1);
    chk("t1_beat0", 32'(got_q[0]), 32'h10005);
    chk("t1_path", 32'(last_path), 32'h11);
    chk("t1_depth", 32'(last_depth), 32'd2);
    chk("t1_code", 32'(last_code), 32'd3);
    chk("t1_term", 32'(last_term), 32'd0);

    // terminating flag argument
    tok_a[0] = 16'h0010; tok_a[1] = 16'hC001; tok_a[2] = 16'h0007;
    run_job(3, 8'd5);
    chk("t2_beat0", 32'(got_q[0]), 32'h0C001);
    chk("t2_beat1", 32'(got_q[1]), 32'h10007);
    chk("t2_term", 32'(last_term), 32'd1);
    chk("t2_code", 32'(last_code), 32'd5);

    // argument overflow: nine args, eight forwarded, error result
    for (int i = 0; i < 9; i++) tok_a[i] = 16'h0101 + 16'(i);
    run_job(9, 8'd9);
    chk("t3_nbeats", 32'(got_q.size()), 32'd8);
    chk("t3_beat7", 32'(got_q[7]), 32'h00108);
    chk("t3_err", 32'(last_err), 32'd1);
    chk("t3_code", 32'(last_code), 32'd1);

    // exactly MAX_ARGS args is fine
    run_job(8, 8'd4);
    chk("t4_last", 32'(got_q[7]), 32'h10108);
    chk("t4_err", 32'(last_err), 32'd0);

    // matched token with s_last: no beats, x_go the next cycle
    got_q.delete();
    tok_a[0] = 16'h0010;
    prep(1, 8'd6);
    drive_tok(16'h0010, 1'b1);
    @(negedge clk);
    chk("t5_x_go_next", 32'(x_go), 32'd1);
    finish_job();
    chk("t5_nbeats", 32'(got_q.size()), 32'd0);
    chk("t5_depth", 32'(last_depth), 32'd1);

    // depth full: third command ID becomes an argument
    tok_a[0] = 16'h0010; tok_a[1] = 16'h0020; tok_a[2] = 16'h0030; tok_a[3] = 16'h0040;
    run_job(4, 8'd2);
    chk("t6_beat0", 32'(got_q[0]), 32'h00030);
    chk("t6_path", 32'(last_path), 32'h11);

    // root job: flag token first, later command ID is just an argument
    tok_a[0] = 16'h8010; tok_a[1] = 16'h0010;
    run_job(2, 8'd7);
    chk("t7_depth", 32'(last_depth), 32'd0);
    chk("t7_nbeats", 32'(got_q.size()), 32'd2);

    // duplicate table entries: lowest slot wins
    cmd_table = {16'h0040, 16'h0020, 16'h0020, 16'h0010};
    tok_a[0] = 16'h0020;
    run_job(1, 8'd8);
    chk("t8_path", 32'(last_path), 32'h02);
    cmd_table = {16'h0040, 16'h0030, 16'h0020, 16'h0010};

    // non-terminating flag then terminating ones
    tok_a[0] = 16'h8001; tok_a[1] = 16'hC002; tok_a[2] = 16'hC003;
    run_job(3, 8'd11);
    chk("t9_term", 32'(last_term), 32'd1);

    // back-pressure: output held, no input accepted, nothing lost
    got_q.delete();
    tok_a[0] = 16'h0001; tok_a[1] = 16'h0002; tok_a[2] = 16'h0003;
    prep(3, 8'd12);
    m_ready = 1'b0;
    drive_tok(16'h0001, 1'b0);
    s_valid = 1'b1; s_data = 16'h0002; s_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t10_m_valid", 32'(m_valid), 32'd1);
      chk("t10_m_data", 32'(m_data), 32'h0001);
      chk("t10_s_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    drive_tok(16'h0002, 1'b0);
    drive_tok(16'h0003, 1'b1);
    finish_job();
    chk("t10_nbeats", 32'(got_q.size()), 32'd3);
    chk("t10_beat2", 32'(got_q[2]), 32'h10003);

    // reset in the middle of a job
    for (int i = 0; i < 5; i++) tok_a[i] = 16'h0201 + 16'(i);
    got_q.delete();
    prep(5, 8'd0);
    for (int i = 0; i < 3; i++) drive_tok(tok_a[i], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t11_m_out", 32'({m_valid, m_last, m_data}), 32'd0);
    chk("t11_x_out", 32'({x_go, x_term}), 32'd0);
    chk("t11_r_out", 32'({r_valid, r_err, r_code, r_path, r_depth}), 32'd0);
    chk("t11_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tok_a[0] = 16'h0030; tok_a[1] = 16'h0009;
    run_job(2, 8'd13);
    chk("t11_fresh_path", 32'(last_path), 32'h03);
    chk("t11_fresh_code", 32'(last_code), 32'd13);
    chk("t11_fresh_beat", 32'(got_q[0]), 32'h10009);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
